// File: rtl/gray_counter_updown.sv
// gray_counter_updown: parametrised up/down Gray-code counter.
// Binary state is kept internally; Gray and binary outputs are registered in
// the same edge so they are always coherent. Supports enable, direction,
// synchronous clear, parallel Gray load, wrap or saturate at the range ends,
// a terminal-count flag and a one-cycle wrap pulse.
// Optional feature macro: GRAY_CNT_STEP_CHECK_EN enables a sticky checker
// that flags any gray_out transition of more than one bit that was not
// caused by clear or load. Without the macro err is tied low.
module gray_counter_updown #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray to binary: the MSB passes through, each lower bit folds in the bit above.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;

    // Terminal count depends on the live direction input, not on a registered copy.
    always_comb begin
        if (up) begin
            tc = (bin_q == MAX_C);
        end else begin
            tc = (bin_q == ZERO_C);
        end
    end

    // Next-state: clear beats load beats enable; terminal steps wrap or hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clear) begin
            bin_d = ZERO_C;
        end else if (load) begin
            bin_d = gray2bin(load_gray);
        end else if (en) begin
            if (tc) begin
                if (WRAP) begin
                    bin_d  = up ? ZERO_C : MAX_C;
                    wrap_d = 1'b1;
                end else begin
                    bin_d  = bin_q;
                    wrap_d = 1'b0;
                end
            end else if (up) begin
                bin_d = bin_q + ONE_C;
            end else begin
                bin_d = bin_q - ONE_C;
            end
        end else begin
            bin_d = bin_q;
        end
        gray_d = bin2gray(bin_d);
    end

    // Count, Gray image and wrap pulse all update on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= ZERO_C;
            gray_q <= ZERO_C;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

`ifdef GRAY_CNT_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             skip_q;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] diff_s;
    logic             step_bad_s;

    // A step is bad when more than one Gray bit flipped (x & (x-1) non-zero).
    always_comb begin
        diff_s     = gray_q ^ prev_q;
        step_bad_s = |(diff_s & (diff_s - ONE_C));
        if (clear) begin
            err_d = 1'b0;
        end else if (step_bad_s && !skip_q) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Remember the previous Gray output and whether the last update was a clear/load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= ZERO_C;
            skip_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= gray_q;
            skip_q <= clear | load;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_updown.sv
// Self-checking bench for gray_counter_updown. Two instances share stimulus:
// one wrapping (WRAP=1) and one saturating (WRAP=0). A reference model
// pushes expected outputs to a scoreboard queue when stimulus is driven;
// each scenario task pops and compares after the edge.
module tb_gray_counter_updown;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_gray;

    logic [3:0] gw, bw, gs, bs;
    logic       tcw, ww, ew, tcs, ws, es;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  m_w;
    logic [3:0]  m_s;
    logic [19:0] sb[$];
    logic [19:0] exp_v;
    logic [19:0] obs_v;
    logic        exp_tc;

    gray_counter_updown #(.WIDTH(4), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .gray_out(gw), .bin_out(bw), .tc(tcw), .wrap(ww), .err(ew)
    );

    gray_counter_updown #(.WIDTH(4), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .gray_out(gs), .bin_out(bs), .tc(tcs), .wrap(ws), .err(es)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] g_of(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference next state: {wrap, bin}
    function automatic logic [4:0] mnext(input logic [3:0] b, input bit wr, input logic cl,
                                         input logic ld, input logic [3:0] lg,
                                         input logic e, input logic u);
        logic [3:0] lb;
        lb[3] = lg[3];
        lb[2] = lb[3] ^ lg[2];
        lb[1] = lb[2] ^ lg[1];
        lb[0] = lb[1] ^ lg[0];
        if (cl) return {1'b0, 4'h0};
        if (ld) return {1'b0, lb};
        if (!e) return {1'b0, b};
        if (u && b == 4'hF) return wr ? {1'b1, 4'h0} : {1'b0, 4'hF};
        if (!u && b == 4'h0) return wr ? {1'b1, 4'hF} : {1'b0, 4'h0};
        if (u) return {1'b0, b + 4'd1};
        return {1'b0, b - 4'd1};
    endfunction

    function automatic logic [19:0] obs();
        return {bw, gw, ww, ew, bs, gs, ws, es};
    endfunction

    // Drive one cycle of stimulus at the falling edge, push the expectation, wait for the next falling edge.
    task automatic cycle(input logic cl, input logic ld, input logic [3:0] lg,
                         input logic e, input logic u);
        logic [4:0] nw;
        logic [4:0] ns;
        clear = cl; load = ld; load_gray = lg; en = e; up = u;
        nw = mnext(m_w, 1'b1, cl, ld, lg, e, u);
        ns = mnext(m_s, 1'b0, cl, ld, lg, e, u);
        m_w = nw[3:0];
        m_s = ns[3:0];
        sb.push_back({m_w, g_of(m_w), nw[4], 1'b0, m_s, g_of(m_s), ns[4], 1'b0});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_gray = 4'h0;
        m_w = 4'h0; m_s = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 20'h0) begin
            failures++; $display("FAIL reset_outputs got %h exp %h", obs(), 20'h0);
        end
        checks++;
        if ({tcw, tcs} !== 2'b00) begin
            failures++; $display("FAIL reset_tc_up got %b exp 00", {tcw, tcs});
        end
        up = 1'b0;
        #1;
        checks++;
        if ({tcw, tcs} !== 2'b11) begin
            failures++; $display("FAIL reset_tc_down got %b exp 11", {tcw, tcs});
        end
        @(negedge clk);
        reset = 1'b0; up = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_up_count();
        logic [3:0] tbl [16];
        logic [3:0] prev;
        tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (gw !== tbl[i] || bw !== i[3:0]) begin
                failures++; $display("FAIL up_seq %0d got g=%h b=%h exp g=%h b=%h", i, gw, bw, tbl[i], i[3:0]);
            end
            prev = gw;
            cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++; $display("FAIL up_count step %0d got %h exp %h", i, obs(), exp_v);
            end
            checks++;
            if ($countones(gw ^ prev) != 1) begin
                failures++; $display("FAIL up_one_bit step %0d got %h->%h exp one bit change", i, prev, gw);
            end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v) begin
            failures++; $display("FAIL wrap_load got %h exp %h", obs(), exp_v);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || {bw, gw, ww} !== 9'b0000_0000_1) begin
            failures++; $display("FAIL wrap_up got %h exp %h", obs(), exp_v);
        end
        up = 1'b0;
        #1;
        checks++;
        if (tcw !== 1'b1) begin
            failures++; $display("FAIL wrap_tc_down got %b exp 1", tcw);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || {bw, gw, ww} !== 9'b1111_1000_1) begin
            failures++; $display("FAIL wrap_down got %h exp %h", obs(), exp_v);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || ww !== 1'b0) begin
            failures++; $display("FAIL wrap_pulse_end got %h exp %h", obs(), exp_v);
        end
    endtask

    task automatic test_saturate();
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v) begin
            failures++; $display("FAIL sat_load got %h exp %h", obs(), exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v || {bs, gs, ws, tcs} !== 10'b1111_1000_0_1) begin
                failures++; $display("FAIL sat_hold %0d got %h tc=%b exp %h", i, obs(), tcs, exp_v);
            end
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || {bs, gs} !== 8'hE9) begin
            failures++; $display("FAIL sat_down got %h exp %h", obs(), exp_v);
        end
    endtask

    task automatic test_load();
        cycle(1'b0, 1'b1, 4'hD, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || {bw, gw, bs, gs} !== 16'h9D9D) begin
            failures++; $display("FAIL load_d got %h exp %h", obs(), exp_v);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || {bw, gw} !== 8'hAF) begin
            failures++; $display("FAIL load_step got %h exp %h", obs(), exp_v);
        end
    endtask

    task automatic test_priority();
        cycle(1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || bw !== 4'h5) begin
            failures++; $display("FAIL prio_load5 got %h exp %h", obs(), exp_v);
        end
        cycle(1'b1, 1'b1, 4'hA, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || {bw, gw, bs, gs} !== 16'h0000) begin
            failures++; $display("FAIL prio_clear got %h exp %h", obs(), exp_v);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++; $display("FAIL ares_pre %0d got %h exp %h", i, obs(), exp_v);
            end
        end
        load = 1'b1; load_gray = 4'hB;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 20'h0) begin
            failures++; $display("FAIL ares_mid got %h exp %h", obs(), 20'h0);
        end
        @(negedge clk);
        reset = 1'b0; load = 1'b0; en = 1'b0;
        m_w = 4'h0; m_s = 4'h0;
        @(negedge clk);
        checks++;
        if (obs() !== 20'h0) begin
            failures++; $display("FAIL ares_after got %h exp %h", obs(), 20'h0);
        end
    endtask

    task automatic test_random();
        logic e;
        logic u;
        for (int i = 0; i < 256; i++) begin
            e = 1'($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            up = u;
            #1;
            exp_tc = (u && m_w == 4'hF) || (!u && m_w == 4'h0);
            checks++;
            if (tcw !== exp_tc) begin
                failures++; $display("FAIL rand_tc %0d got %b exp %b", i, tcw, exp_tc);
            end
            cycle(1'b0, 1'b0, 4'h0, e, u);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++; $display("FAIL rand_step %0d got %h exp %h", i, obs(), exp_v);
            end
        end
    endtask

`ifdef GRAY_CNT_STEP_CHECK_EN
    task automatic test_checker();
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        void'(sb.pop_front());
        en = 1'b1; up = 1'b1;
        force dut_w.bin_q = 4'hA;
        @(posedge clk);
        @(negedge clk);
        release dut_w.bin_q;
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ew !== 1'b1) begin
            failures++; $display("FAIL chk_err_set got %b exp 1", ew);
        end
        @(negedge clk);
        checks++;
        if (ew !== 1'b1) begin
            failures++; $display("FAIL chk_err_sticky got %b exp 1", ew);
        end
        m_w = 4'h0; m_s = 4'h0;
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        @(negedge clk);
        checks++;
        if (obs() !== exp_v) begin
            failures++; $display("FAIL chk_err_clear got %h exp %h", obs(), exp_v);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_wrap();
        test_saturate();
        test_load();
        test_priority();
        test_async_reset();
        test_random();
`ifdef GRAY_CNT_STEP_CHECK_EN
        test_checker();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_counter_updown.md
# gray_counter_updown

Parametrised up/down Gray-code counter. It extends the free-running n-bit Gray counter with the following:
- enable, direction and synchronous clear;
- parallel load of a Gray value;
- wrap or saturate at the end of the range;
- terminal-count and wrap indications.

It provides the Gray-coded pointers and sequence generators for multi-clock blocks, such as async FIFO pointers and position counters. Gray and binary outputs are registered and always coherent: no cycle of lag between them.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- WRAP, 1, 1 = wrap at range ends; 0 = saturate at 0 and 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear to zero.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_gray  input  WIDTH  Gray-coded value to load.
- gray_out  output  WIDTH  registered Gray count.
- bin_out  output  WIDTH  registered binary count; gray_out == bin_out ^ (bin_out >> 1) every cycle.
- tc  output  1  terminal count. Combinational: (up && bin_out == 2^WIDTH-1) || (!up && bin_out == 0).
- wrap  output  1  registered one-cycle pulse in the cycle after a wrap step.
- err  output  1  sticky Gray-step error (see Configuration).

## Operation
- Internal state is the binary count `bin`. gray_out is registered from next-state `bin_nx ^ (bin_nx >> 1)` in the same edge as bin_out.
- Priority per cycle, highest first: clear, load, en, hold.
- **clear:** bin <= 0; gray_out <= 0; wrap <= 0.
- **load:** bin <= gray2bin(load_gray), with b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i]. wrap <= 0. Loading any Gray value is legal.
- **en && up:** bin <= bin + 1, modulo 2^WIDTH.
- **en && !up:** bin <= bin - 1, modulo 2^WIDTH.
- **Terminal step** (en && tc && !clear && !load):
  - WRAP=1: the count wraps (max -> 0 up, 0 -> max down) and wrap <= 1.
  - WRAP=0: the count holds and wrap stays 0.
- wrap is 0 in every cycle not immediately following a wrap step.
- Changing `up` between cycles is legal. The step direction is always taken from `up` sampled at that edge.
- Arithmetic is WIDTH bits, unsigned, with no carry out.

## Timing
- Reset (async assert, sync to clk on release): bin_out = 0, gray_out = 0, wrap = 0, err = 0. tc then reflects `up` (1 if up = 0).
- **Latency:** a step, load or clear sampled at edge N is visible on gray_out and bin_out after edge N.
- wrap is asserted for exactly the one cycle after the wrap edge.
- A reset mid-operation overrides everything immediately, including a pending load.
- Simultaneous clear + load + en: clear wins; the counter equals 0 after the edge.
- Simultaneous load + en: load wins; no step is applied on that edge.
- With en = 0, outputs hold indefinitely, except tc, which follows `up`.

## Configuration
- Macro: GRAY_CNT_STEP_CHECK_EN.
- **Defined:** a checker registers the previous gray_out. Err is set when both of the following hold for consecutive outputs:
  - the popcount of (gray_out ^ prev) is greater than 1;
  - the transition was not caused by clear or load.
  
  Once set, err stays high until reset or clear.
- **Undefined:** err is tied to 0 and no checker logic is generated. The port list is identical in both builds.

## Test plan
- **Reset and up-count:** with WIDTH=4, release reset and hold en=1, up=1 for 16 cycles. gray_out must run 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8. bin_out must run 0..F. Exactly one bit changes per step.
- **Wrap, both directions:** with WRAP=1, count up from F. Expect bin 0, gray 0, and wrap=1 for one cycle. Then set up=0 at 0: expect tc=1, next bin F, gray 8, and wrap=1.
- **Saturate:** with WRAP=0, at bin F with up=1 and en=1 for 3 cycles, the count holds at F (gray 8), tc=1 and wrap=0. Then set up=0: expect next bin E (gray 9).
- **Load:** set load=1, load_gray=4'hD with en=1. The next cycle must show bin_out=9 and gray_out=D. Then an up step gives bin A, gray F.
- **Priority and reset:** assert clear, load and en together at bin 5; expect 0. Assert reset asynchronously mid-count; outputs go to 0 before the next clk edge.
- **Checker:** with GRAY_CNT_STEP_CHECK_EN defined, err stays 0 across a full 256-step random en/up run. A forced illegal bin_out jump makes err rise and stay high until clear.
